// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: coin credit, item selection, dispenser handshake and change payout.
// Optional ack timeout in DISPENSE is enabled with `define VEND_ACK_TIMEOUT_EN.
module vend_txn_ctrl #(
  parameter int PRICE_A    = 3,
  parameter int PRICE_B    = 4,
  parameter int MAX_CREDIT = 8,
  parameter int TIMEOUT    = 255,
  parameter int CW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    coin,
  input  logic [1:0]    sel,
  input  logic          cancel,
  input  logic          disp_ack,
  output logic          disp_req,
  output logic [1:0]    disp_item,
  output logic          chg_pulse,
  output logic          coin_rej,
  output logic [CW-1:0] credit,
  output logic          busy,
  output logic          fault
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW:0]   PA       = (CW+1)'(PRICE_A);
  localparam logic [CW:0]   PB       = (CW+1)'(PRICE_B);
  localparam logic [CW:0]   MAXC     = (CW+1)'(MAX_CREDIT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] credit_n;
  logic [TW-1:0] tmo_cnt, cnt_n;
  logic          req_n, chg_n, rej_n;
  logic [1:0]    item_n;

  logic [CW:0]   coin_val, sum, price_sel, credit_ext;
  logic          coin_vld, sel_vld;

  always_comb begin
    case (coin)
      2'b01:   coin_val = (CW+1)'(1);
      2'b10:   coin_val = (CW+1)'(2);
      default: coin_val = '0;
    endcase
  end

  assign coin_vld   = (coin == 2'b01) || (coin == 2'b10);
  assign sel_vld    = (sel == 2'b01) || (sel == 2'b10);
  assign price_sel  = (sel == 2'b01) ? PA : PB;
  // Ceiling check is one bit wider so an overflowing sum cannot wrap under MAX_CREDIT.
  assign credit_ext = {1'b0, credit};
  assign sum        = credit_ext + coin_val;
  assign busy       = (state == DISPENSE) || (state == CHANGE);

`ifdef VEND_ACK_TIMEOUT_EN
  logic        fault_n;
  logic [CW:0] item_price;
  assign item_price = (disp_item == 2'b01) ? PA : PB;
`endif

  always_comb begin
    state_n  = state;
    credit_n = credit;
    cnt_n    = tmo_cnt;
    req_n    = disp_req;
    item_n   = disp_item;
    chg_n    = 1'b0;
    rej_n    = 1'b0;
`ifdef VEND_ACK_TIMEOUT_EN
    fault_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (coin_vld) begin
          if (sum <= MAXC) begin
            credit_n = sum[CW-1:0];
            state_n  = COLLECT;
            cnt_n    = '0;
          end else begin
            rej_n = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (cancel) begin
          state_n = CHANGE;
          rej_n   = coin_vld;
          cnt_n   = '0;
        end else if (sel_vld && (credit_ext >= price_sel)) begin
          // Affordability uses credit before any same-cycle coin; that coin is bounced.
          credit_n = credit - price_sel[CW-1:0];
          req_n    = 1'b1;
          item_n   = sel;
          state_n  = DISPENSE;
          rej_n    = coin_vld;
          cnt_n    = '0;
        end else begin
          if (coin_vld) begin
            if (sum <= MAXC) credit_n = sum[CW-1:0];
            else             rej_n    = 1'b1;
          end
          if (coin_vld || sel_vld) begin
            cnt_n = '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state_n = CHANGE;
            cnt_n   = '0;
          end else begin
            cnt_n = tmo_cnt + TW'(1);
          end
        end
      end
      DISPENSE: begin
        rej_n = coin_vld;
        if (disp_ack) begin
          req_n   = 1'b0;
          item_n  = 2'b00;
          state_n = (credit != '0) ? CHANGE : IDLE;
          cnt_n   = '0;
        end
`ifdef VEND_ACK_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          // Dispenser never answered: give the price back and refund everything.
          req_n    = 1'b0;
          item_n   = 2'b00;
          credit_n = credit + item_price[CW-1:0];
          fault_n  = 1'b1;
          state_n  = CHANGE;
          cnt_n    = '0;
        end else begin
          cnt_n = tmo_cnt + TW'(1);
        end
`endif
      end
      CHANGE: begin
        rej_n = coin_vld;
        if (credit != '0) begin
          chg_n    = 1'b1;
          credit_n = credit - CW'(1);
          if (credit == CW'(1)) state_n = IDLE;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      credit    <= '0;
      tmo_cnt   <= '0;
      disp_req  <= 1'b0;
      disp_item <= 2'b00;
      chg_pulse <= 1'b0;
      coin_rej  <= 1'b0;
    end else begin
      state     <= state_n;
      credit    <= credit_n;
      tmo_cnt   <= cnt_n;
      disp_req  <= req_n;
      disp_item <= item_n;
      chg_pulse <= chg_n;
      coin_rej  <= rej_n;
    end
  end

`ifdef VEND_ACK_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault <= 1'b0;
    else      fault <= fault_n;
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed self-checking bench for vend_txn_ctrl with hand-computed expectations.
module tb_vend_txn_ctrl;
  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin, sel;
  logic       cancel, disp_ack;
  logic       disp_req, chg_pulse, coin_rej, busy, fault;
  logic [1:0] disp_item;
  logic [3:0] credit;

  int tests = 0;
  int fails = 0;

  vend_txn_ctrl #(.PRICE_A(3), .PRICE_B(4), .MAX_CREDIT(8), .TIMEOUT(TIMEOUT), .CW(4)) dut (
    .clk(clk), .rst(rst), .coin(coin), .sel(sel), .cancel(cancel), .disp_ack(disp_ack),
    .disp_req(disp_req), .disp_item(disp_item), .chg_pulse(chg_pulse), .coin_rej(coin_rej),
    .credit(credit), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for exactly one rising edge, then sample 1ns after it.
  task automatic cyc(input logic [1:0] c, input logic [1:0] s, input logic cn, input logic ak);
    coin = c; sel = s; cancel = cn; disp_ack = ak;
    @(posedge clk); #1;
    coin = 2'b00; sel = 2'b00; cancel = 1'b0; disp_ack = 1'b0;
  endtask

  initial begin
    int npulse, first, fi;
    rst = 1'b0; coin = 2'b00; sel = 2'b00; cancel = 1'b0; disp_ack = 1'b0;
    #3;
    chk("rst_req", disp_req, 0);
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_chg", chg_pulse, 0);
    chk("rst_fault", fault, 0);
    @(posedge clk); #1; rst = 1'b1;

    // idle ignores sel/cancel
    cyc(2'b00, 2'b01, 1'b1, 1'b0);
    chk("idle_sel_req", disp_req, 0);
    chk("idle_sel_busy", busy, 0);

    // three half-units buy item A exactly
    cyc(2'b01, 2'b00, 1'b0, 1'b0); chk("t1_cr1", credit, 1);
    cyc(2'b01, 2'b00, 1'b0, 1'b0); chk("t1_cr2", credit, 2);
    cyc(2'b01, 2'b00, 1'b0, 1'b0); chk("t1_cr3", credit, 3);
    cyc(2'b00, 2'b01, 1'b0, 1'b0);
    chk("t1_req", disp_req, 1); chk("t1_item", disp_item, 2'b01); chk("t1_cr0", credit, 0);
    cyc(2'b00, 2'b00, 1'b0, 1'b0);
    chk("t1_hold_req", disp_req, 1); chk("t1_hold_item", disp_item, 2'b01);
    cyc(2'b00, 2'b00, 1'b0, 1'b1);
    chk("t1_ack_req", disp_req, 0); chk("t1_ack_item", disp_item, 0);
    chk("t1_ack_busy", busy, 0); chk("t1_ack_chg", chg_pulse, 0);
    cyc(2'b00, 2'b00, 1'b0, 1'b0); chk("t1_nochg", chg_pulse, 0);

    // 2+2+1 = 5, item B costs 4, one half-unit back
    cyc(2'b10, 2'b00, 1'b0, 1'b0); chk("t2_cr2", credit, 2);
    cyc(2'b10, 2'b00, 1'b0, 1'b0); chk("t2_cr4", credit, 4);
    cyc(2'b01, 2'b00, 1'b0, 1'b0); chk("t2_cr5", credit, 5);
    cyc(2'b00, 2'b10, 1'b0, 1'b0);
    chk("t2_req", disp_req, 1); chk("t2_item", disp_item, 2'b10); chk("t2_cr1", credit, 1);
    cyc(2'b00, 2'b00, 1'b0, 1'b1);
    chk("t2_ack_req", disp_req, 0); chk("t2_ack_busy", busy, 1); chk("t2_ack_chg", chg_pulse, 0);
    cyc(2'b00, 2'b00, 1'b0, 1'b0);
    chk("t2_chg", chg_pulse, 1); chk("t2_chg_cr", credit, 0); chk("t2_idle", busy, 0);
    cyc(2'b00, 2'b00, 1'b0, 1'b0); chk("t2_chg_end", chg_pulse, 0);

    // insufficient sel ignored, then cancel refunds two pulses
    cyc(2'b10, 2'b00, 1'b0, 1'b0); chk("t3_cr2", credit, 2);
    cyc(2'b00, 2'b01, 1'b0, 1'b0);
    chk("t3_nosel_req", disp_req, 0); chk("t3_nosel_cr", credit, 2); chk("t3_nosel_busy", busy, 0);
    cyc(2'b01, 2'b00, 1'b1, 1'b0);
    chk("t3_cancel_busy", busy, 1); chk("t3_cancel_rej", coin_rej, 1); chk("t3_cancel_cr", credit, 2);
    cyc(2'b00, 2'b00, 1'b0, 1'b0); chk("t3_p1", chg_pulse, 1); chk("t3_p1_cr", credit, 1);
    cyc(2'b00, 2'b00, 1'b0, 1'b0); chk("t3_p2", chg_pulse, 1); chk("t3_p2_cr", credit, 0);
    chk("t3_idle", busy, 0);
    cyc(2'b00, 2'b00, 1'b0, 1'b0); chk("t3_end", chg_pulse, 0);

    // ceiling at 8, coin in DISPENSE rejected, four-pulse refund
    for (int i = 1; i <= 4; i++) begin
      cyc(2'b10, 2'b00, 1'b0, 1'b0); chk("t4_fill", credit, 2 * i);
    end
    cyc(2'b01, 2'b00, 1'b0, 1'b0); chk("t4_rej", coin_rej, 1); chk("t4_rej_cr", credit, 8);
    cyc(2'b00, 2'b00, 1'b0, 1'b0); chk("t4_rej_off", coin_rej, 0);
    cyc(2'b00, 2'b10, 1'b0, 1'b0); chk("t4_req", disp_req, 1); chk("t4_cr4", credit, 4);
    cyc(2'b01, 2'b00, 1'b0, 1'b0);
    chk("t4_disp_rej", coin_rej, 1); chk("t4_disp_cr", credit, 4); chk("t4_disp_req", disp_req, 1);
    cyc(2'b00, 2'b00, 1'b0, 1'b1); chk("t4_ack_req", disp_req, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(2'b00, 2'b00, 1'b0, 1'b0);
      chk("t4_pulse", chg_pulse, 1); chk("t4_pulse_cr", credit, 4 - i);
    end
    chk("t4_idle", busy, 0);
    cyc(2'b00, 2'b00, 1'b0, 1'b0); chk("t4_end", chg_pulse, 0);

    // COLLECT inactivity timeout refunds one half-unit
    cyc(2'b01, 2'b00, 1'b0, 1'b0); chk("t5_cr1", credit, 1);
    npulse = 0; first = 0;
    for (int i = 1; i <= TIMEOUT + 20; i++) begin
      cyc(2'b00, 2'b00, 1'b0, 1'b0);
      if (chg_pulse) begin
        npulse++;
        if (first == 0) first = i;
      end
      if (npulse > 0 && !busy) break;
    end
    chk("t5_first_pulse_cycle", first, TIMEOUT + 1);
    chk("t5_npulse", npulse, 1);
    chk("t5_cr0", credit, 0);
    chk("t5_idle", busy, 0);

`ifdef VEND_ACK_TIMEOUT_EN
    // withheld ack: fault pulse, price restored, full refund of 4
    cyc(2'b10, 2'b00, 1'b0, 1'b0);
    cyc(2'b10, 2'b00, 1'b0, 1'b0);
    cyc(2'b00, 2'b01, 1'b0, 1'b0); chk("t7_req", disp_req, 1); chk("t7_cr1", credit, 1);
    fi = 0;
    for (int i = 1; i <= TIMEOUT + 20; i++) begin
      cyc(2'b00, 2'b00, 1'b0, 1'b0);
      if (fault) begin fi = i; break; end
    end
    chk("t7_fault_cycle", fi, TIMEOUT);
    chk("t7_cr_restored", credit, 4);
    chk("t7_req_drop", disp_req, 0);
    chk("t7_busy", busy, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(2'b00, 2'b00, 1'b0, 1'b0);
      chk("t7_fault_off", fault, 0);
      chk("t7_pulse", chg_pulse, 1);
    end
    chk("t7_cr0", credit, 0);
    chk("t7_idle", busy, 0);
`else
    chk("fault_tied", fault, 0);
`endif

    // async reset mid-DISPENSE with credit 2
    cyc(2'b10, 2'b00, 1'b0, 1'b0);
    cyc(2'b10, 2'b00, 1'b0, 1'b0);
    cyc(2'b01, 2'b00, 1'b0, 1'b0);
    cyc(2'b00, 2'b01, 1'b0, 1'b0); chk("t6_req", disp_req, 1); chk("t6_cr2", credit, 2);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_req", disp_req, 0);
    chk("t6_rst_cr", credit, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_item", disp_item, 0);
    @(posedge clk); #1; rst = 1'b1;
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(2'b00, 2'b00, 1'b0, (i == 0) ? 1'b1 : 1'b0);
      if (chg_pulse) npulse++;
    end
    chk("t6_no_pulses", npulse, 0);
    chk("t6_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
